// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the boot-time flash-to-RAM copier.
// The ramio write_type encodings are common to ramio, the core and this loader.
package flash_loader_pkg;

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_CMD      = 3'd1,
        ST_READ     = 3'd2,
        ST_RAM_REQ  = 3'd3,
        ST_RAM_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    localparam logic [1:0] WT_NONE = 2'd0;
    localparam logic [1:0] WT_BYTE = 2'd1;
    localparam logic [1:0] WT_HALF = 2'd2;
    localparam logic [1:0] WT_WORD = 2'd3;

    localparam int SPI_MAX_BITS = 32;

    // Little-endian lane insert: byte idx lands in bits [8*idx+7:8*idx].
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/flash_spi_shifter.sv
// SPI mode-0 shifter: 2 clk per bit, MSB first, variable length up to Width bits.
// tx_data is MSB-aligned; ready marks the edge that samples the final bit.
module flash_spi_shifter
    import flash_loader_pkg::*;
#(
    parameter int Width   = SPI_MAX_BITS,
    parameter int RxWidth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(Width+1)-1:0] len,
    input  logic [Width-1:0]           tx_data,
    input  logic                       miso,
    output logic                       sclk,
    output logic                       mosi,
    output logic                       ready,
    output logic [RxWidth-1:0]         rx_data
);

    localparam int CntW = $clog2(Width + 1);

    logic               active_q, active_d;
    logic               phase_q, phase_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [Width-1:0]   tx_q, tx_d;
    logic [RxWidth-1:0] rx_q, rx_d;
    logic               last_s;

    assign last_s  = active_q & phase_q & (cnt_q == CntW'(1));
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ready   = last_s;
    // Includes the bit being sampled this edge so the caller can capture on ready.
    assign rx_data = {rx_q[RxWidth-2:0], miso};

    // Bit sequencing: phase 0 presents mosi with sclk low, phase 1 raises sclk.
    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (start) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            sclk_d   = 1'b0;
            cnt_d    = len;
            mosi_d   = tx_data[Width-1];
            tx_d     = {tx_data[Width-2:0], 1'b0};
            rx_d     = {RxWidth{1'b0}};
        end else if (active_q && !phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
        end else if (active_q) begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            cnt_d   = cnt_q - CntW'(1);
            rx_d    = {rx_q[RxWidth-2:0], miso};
            if (last_s) begin
                active_d = 1'b0;
                mosi_d   = 1'b0;
            end else begin
                mosi_d = tx_q[Width-1];
                tx_d   = {tx_q[Width-2:0], 1'b0};
            end
        end else begin
            sclk_d = 1'b0;
            mosi_d = 1'b0;
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cnt_q    <= {CntW{1'b0}};
            tx_q     <= {Width{1'b0}};
            rx_q     <= {RxWidth{1'b0}};
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

endmodule

// File: rtl/flash_loader.sv
// Boot copier: reads an image from SPI flash (READ 0x03) and writes it to RAM
// as little-endian 32-bit words through ramio, then holds done high.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int unsigned StartupWaitCycles  = 1_000_000,
    parameter int unsigned FlashTransferBytes = 4096,
    parameter logic [23:0] FlashStartAddress  = 24'h00_0000,
    parameter logic [31:0] RamStartAddress    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        done,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic        ramio_busy,
    output logic        flash_clk,
    input  logic        flash_miso,
    output logic        flash_mosi,
    output logic        flash_cs
);

    localparam int ByteCntW = (FlashTransferBytes > 0) ? $clog2(FlashTransferBytes + 1) : 1;

    state_e              state_q, state_d;
    logic [31:0]         wait_cnt_q, wait_cnt_d;
    logic [ByteCntW-1:0] bytes_left_q, bytes_left_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic                done_q, done_d;
    logic                en_q, en_d;
    logic [1:0]          wt_q, wt_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                cs_q, cs_d;

    logic                spi_start_s;
    logic [5:0]          spi_len_s;
    logic [31:0]         spi_tx_s;
    logic                spi_ready_s;
    logic [7:0]          spi_rx_s;

    flash_spi_shifter #(
        .Width   (SPI_MAX_BITS),
        .RxWidth (8)
    ) u_spi (
        .clk     (clk),
        .rst     (rst),
        .start   (spi_start_s),
        .len     (spi_len_s),
        .tx_data (spi_tx_s),
        .miso    (flash_miso),
        .sclk    (flash_clk),
        .mosi    (flash_mosi),
        .ready   (spi_ready_s),
        .rx_data (spi_rx_s)
    );

    assign done             = done_q;
    assign ramio_enable     = en_q;
    assign ramio_write_type = wt_q;
    assign ramio_address    = addr_q;
    assign ramio_data_in    = data_q;
    assign flash_cs         = cs_q;

    // Next-state logic; the next SPI transfer starts on the edge that finishes the previous one.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        bytes_left_d = bytes_left_q;
        byte_idx_d   = byte_idx_q;
        done_d       = done_q;
        en_d         = 1'b0;
        wt_d         = wt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cs_d         = cs_q;
        spi_start_s  = 1'b0;
        spi_len_s    = 6'd8;
        spi_tx_s     = 32'h0000_0000;
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == StartupWaitCycles) begin
                    if (FlashTransferBytes == 32'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ST_CMD;
                        cs_d         = 1'b0;
                        addr_d       = RamStartAddress;
                        bytes_left_d = ByteCntW'(FlashTransferBytes);
                        spi_start_s  = 1'b1;
                        spi_len_s    = 6'd32;
                        spi_tx_s     = {FLASH_CMD_READ, FlashStartAddress};
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            ST_CMD: begin
                if (spi_ready_s) begin
                    state_d     = ST_READ;
                    spi_start_s = 1'b1;
                    data_d      = 32'h0000_0000;
                    byte_idx_d  = 2'd0;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_READ: begin
                if (spi_ready_s) begin
                    data_d       = put_byte(data_q, byte_idx_q, spi_rx_s);
                    bytes_left_d = bytes_left_q - ByteCntW'(1);
                    if ((byte_idx_q == 2'd3) || (bytes_left_q == ByteCntW'(1))) begin
                        state_d = ST_RAM_REQ;
                        wt_d    = WT_WORD;
                    end else begin
                        byte_idx_d  = byte_idx_q + 2'd1;
                        spi_start_s = 1'b1;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_RAM_REQ: begin
                if (!ramio_busy) begin
                    en_d    = 1'b1;
                    state_d = ST_RAM_WAIT;
                end else begin
                    state_d = ST_RAM_REQ;
                end
            end
            ST_RAM_WAIT: begin
                wt_d = WT_NONE;
                if (!ramio_busy) begin
                    addr_d = addr_q + 32'd4;
                    if (bytes_left_q != {ByteCntW{1'b0}}) begin
                        state_d     = ST_READ;
                        spi_start_s = 1'b1;
                        data_d      = 32'h0000_0000;
                        byte_idx_d  = 2'd0;
                    end else begin
                        state_d = ST_DONE;
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_RAM_WAIT;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                cs_d   = 1'b1;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Loader FSM and its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT;
            wait_cnt_q   <= 32'd0;
            bytes_left_q <= {ByteCntW{1'b0}};
            byte_idx_q   <= 2'd0;
            done_q       <= 1'b0;
            en_q         <= 1'b0;
            wt_q         <= WT_NONE;
            addr_q       <= 32'h0000_0000;
            data_q       <= 32'h0000_0000;
            cs_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            bytes_left_q <= bytes_left_d;
            byte_idx_q   <= byte_idx_d;
            done_q       <= done_d;
            en_q         <= en_d;
            wt_q         <= wt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cs_q         <= cs_d;
        end
    end

endmodule
